// File: rtl/gecko_writeback_arbiter.sv
// Round-robin merge of the gecko unit result streams onto one registered
// writeback stream, with an optional fixed-priority port and a grant counter.
module gecko_writeback_arbiter #(
   parameter bit  CLOCK_INFO    = 1'b0,
   parameter int  PORTS         = 4,
   parameter type T             = logic [31:0],
   parameter int  PRIORITY_PORT = -1
) (
   input  logic                     clk,
   input  logic                     rst,
   input  logic [PORTS-1:0]         results_in_valid,
   output logic [PORTS-1:0]         results_in_ready,
   input  T                         results_in_payload [PORTS],
   output logic                     result_out_valid,
   input  logic                     result_out_ready,
   output T                         result_out_payload,
   output logic [$clog2(PORTS)-1:0] grant_port,
   output logic [31:0]              grant_count
);

   localparam int PTR_W    = $clog2(PORTS);
   localparam bit PRIO_EN  = (PRIORITY_PORT >= 0) && (PRIORITY_PORT < PORTS);
   localparam int PRIO_IDX = PRIO_EN ? PRIORITY_PORT : 0;

   logic             w_unused_clock_info;
   assign w_unused_clock_info = CLOCK_INFO;

   logic             r_valid;
   T                 r_payload;
   logic [PTR_W-1:0] r_grant;
   logic [PTR_W-1:0] r_rr_ptr;
   logic [31:0]      r_count;

   logic             w_load_en;
   logic             w_any;
   logic             w_prio_hit;
   logic             w_found;
   logic [PTR_W-1:0] w_rr_sel;
   logic [PTR_W-1:0] w_sel;
   logic [PTR_W-1:0] w_next_ptr;

   assign w_load_en = !r_valid || result_out_ready;
   assign w_any     = |results_in_valid;

   always_comb begin
      int idx;
      w_found    = 1'b0;
      w_rr_sel   = '0;
      idx        = 0;
      w_prio_hit = PRIO_EN && results_in_valid[PRIO_IDX];
      // Scan upward from the round-robin pointer, wrapping at PORTS.
      for (int k = 0; k < PORTS; k++) begin
         idx = (int'(r_rr_ptr) + k) % PORTS;
         if (!w_found && results_in_valid[idx]) begin
            w_found  = 1'b1;
            w_rr_sel = PTR_W'(idx);
         end
      end
      w_sel = w_prio_hit ? PTR_W'(PRIO_IDX) : w_rr_sel;
   end

   assign w_next_ptr = (w_sel == PTR_W'(PORTS - 1)) ? '0 : w_sel + 1'b1;

   always_comb begin
      results_in_ready = '0;
      for (int i = 0; i < PORTS; i++) begin
         results_in_ready[i] = !rst && w_load_en && results_in_valid[i] &&
                               (w_sel == PTR_W'(i));
      end
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         r_valid   <= 1'b0;
         r_payload <= '0;
         r_grant   <= '0;
         r_rr_ptr  <= '0;
         r_count   <= '0;
      end else if (w_load_en) begin
         r_valid <= w_any;
         if (w_any) begin
            r_payload <= results_in_payload[w_sel];
            r_grant   <= w_sel;
            if (r_count != 32'hFFFF_FFFF) r_count <= r_count + 32'd1;
            // A priority-path win leaves the rotation untouched so the others stay fair.
            if (!w_prio_hit) r_rr_ptr <= w_next_ptr;
         end
      end
   end

   assign result_out_valid   = r_valid;
   assign result_out_payload = r_payload;
   assign grant_port         = r_grant;
   assign grant_count        = r_count;

endmodule

// File: doc/gecko_writeback_arbiter.md
# gecko_writeback_arbiter

Round-robin arbiter that merges the per-unit result streams of the gecko core onto one registered result stream consumed by the register-file writeback. The four sources are execute, memory, system and float. It sits between the unit result streams and the writeback register file write port. It guarantees starvation-free sharing of that single write port, with a one-cycle registered output.

## Interface

Parameters:
- `CLOCK_INFO`, `'b0`: std_clock_info_t, passed through for clock annotation only.
- `PORTS`, `4`: number of requesting streams; legal range 2..8.
- `T`, `gecko_operation_t`: payload type of every input and of the output.
- `PRIORITY_PORT`, `-1`: if 0..PORTS-1, that port wins whenever valid (fixed priority). If -1, pure round-robin.

Ports:
- `clk`  in  1  clock.
- `rst`  in  1  reset; synchronous, active-high.
- `results_in`  in  stream_intf #(T) [PORTS]  requester streams (valid/ready/payload).
- `result_out`  out  stream_intf #(T)  merged stream toward writeback.
- `grant_port`  out  $clog2(PORTS)  source index of the payload currently held in `result_out`.
- `grant_count`  out  32  saturating count of accepted transfers since reset (debug/perf).

## Operation

- **Output register:** holds `result_out.valid`, `result_out.payload` and `grant_port`.
  - Register may load when `load_en = !result_out.valid || result_out.ready`.
- **Arbitration (combinational, each cycle):**
  - If `PRIORITY_PORT` ≥ 0 and that port is valid, it is selected.
  - Otherwise, scan ports starting at `rr_ptr` upward, modulo PORTS. The first valid port is selected.
- **Ready generation:** `results_in[i].ready = load_en && (i == selected) && results_in[i].valid`.
  - At most one ready is high per cycle.
  - Ready never depends on other ports' payloads.
- **Transfer:** on a cycle with `load_en` and any input valid, the output register takes the selected payload, `valid=1` and `grant_port=selected`.
  - `rr_ptr` becomes `(selected+1) mod PORTS`, wrapping from PORTS-1 to 0.
  - `grant_count` increments, saturating at 0xFFFF_FFFF.
- **Idle load:** `load_en` with no input valid: `valid←0`; payload and `grant_port` hold; `rr_ptr` holds.
- **Stall:** no `load_en` (output valid, downstream not ready): register, `rr_ptr` and counter hold. All input readies are 0.
- **Priority-port grants:** the priority port granted through the priority path does not advance `rr_ptr`, so round-robin fairness among the other ports is preserved.

## Timing

- **Latency:** input accepted in cycle N appears on `result_out` in cycle N+1.
- **Throughput:** one transfer per cycle when downstream is always ready.
- **Handshake:**
  - Input transfer happens when `valid && ready` on the rising edge.
  - `result_out.valid` and `result_out.payload` stay stable while `valid && !ready`.
- **Fall-through:** full throughput under `result_out.ready=1`; a held output plus a new input accept in the same cycle is required (pipe-through, no bubble).
- **Fairness:** with all PORTS continuously valid and no priority port, each port is granted exactly once every PORTS cycles.
- **Reset (synchronous, `rst`=1 at clock edge):**
  - `result_out.valid=0`, `result_out.payload=0`, `grant_port=0`, `rr_ptr=0`, `grant_count=0`.
  - All `results_in[i].ready=0` while `rst` is high.
  - Reset mid-stall drops the held output; no transfer completes on that edge.

## Test plan

- **Single source:** port 2 valid for 5 cycles with payloads 0x10..0x14, out.ready=1.
  - Out shows 0x10..0x14 in cycles 1..5, `grant_port=2`, `grant_count=5`.
- **All four valid continuously**, round-robin, out.ready=1.
  - Grant order 0,1,2,3,0,1,2,3.
  - Each input ready exactly once per 4 cycles; no cycle without output valid after cycle 1.
- **Backpressure:** out.ready=0 for 3 cycles while holding payload 0xAA from port 1.
  - Output stays 0xAA with `grant_port=1`.
  - All input readies 0; `rr_ptr` unchanged.
  - On release, next grant is port 2 if valid.
- **`PRIORITY_PORT=1`:** ports 0,1,3 valid continuously.
  - Port 1 granted every cycle; ports 0 and 3 starve by design.
  - Drop port 1's valid, then grants alternate 0,3,0,3.
- **Wrap-around:** `rr_ptr=3` after a port-2 grant; only ports 0 and 3 valid.
  - Port 3 granted, then port 0; `rr_ptr` returns to 1.
- **Reset mid-operation:** assert rst for 1 cycle while out.valid=1 and out.ready=0.
  - Next cycle out.valid=0, `grant_count=0`, `grant_port=0`.
  - First grant afterwards goes to the lowest valid port.
